// File: rtl/counter_pkg.sv
// Shared constants for the synchronous up/down counter slice.
// Holds the default width and the terminal-value helper used by sync_updown_counter.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Highest legal count for a counter with the given number of states.
    function automatic int term_value(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/t_cell.sv
// One counter bit: T flip-flop with synchronous toggle enable, synchronous load
// and asynchronous active-low clear.
module t_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    logic q_q;
    logic q_d;

    // NOTE: default first so every path assigns q_d and no latch is inferred.
    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d;
        end else if (t) begin
            q_d = ~q_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignment only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sync_updown_counter.sv
// Fully synchronous modulo up/down counter built from one t_cell per bit.
// Define COUNTER_SAT_EN to saturate at the ends of the range instead of wrapping.
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_param
        $error("sync_updown_counter: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH-1:0] TERM    = WIDTH'(term_value(MODULUS));
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] cell_d;
    logic             cell_ld;
    logic [WIDTH-1:0] load_clamped;
    logic             ovf_q;
    logic             ovf_d;

    assign tc = (up && count == TERM) || (!up && count == '0);

    assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? TERM : load_val;

    // Bit i toggles when every lower bit is 1 (counting up) or 0 (counting down).
    always_comb begin : toggle_enables
        logic carry;
        logic borrow;
        carry  = 1'b1;
        borrow = 1'b1;
        tgl    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tgl[i] = en & (up ? carry : borrow);
            carry  = carry & count[i];
            borrow = borrow & ~count[i];
        end
    end

    // Stepping off the terminal value goes through the load path so a partial
    // modulus wraps correctly; the saturating build reloads the current value.
    always_comb begin
        cell_ld = load | (en & tc);
        cell_d  = count;
        if (load) begin
            cell_d = load_clamped;
        end else begin
`ifdef COUNTER_SAT_EN
            cell_d = up ? TERM : '0;
`else
            cell_d = up ? '0 : TERM;
`endif
        end
    end

    assign ovf_d = en & ~load & tc;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (tgl[i]),
            .ld  (cell_ld),
            .d   (cell_d[i]),
            .q   (count[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed self-checking bench for sync_updown_counter (full-range and MODULUS=10 instances).
// Define COUNTER_SAT_EN for both RTL and bench to check the saturating build.
module tb_sync_updown_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count16;
    logic       tc16;
    logic       ovf16;
    logic [3:0] count10;
    logic       tc10;
    logic       ovf10;

    int n_tests = 0;
    int n_fail  = 0;

    sync_updown_counter #(.WIDTH(4)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count16),
        .tc       (tc16),
        .ovf      (ovf16)
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count10),
        .tc       (tc10),
        .ovf      (ovf10)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v, input logic dir);
        load = 1'b1; en = 1'b0; up = dir; load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (count16 !== 4'd0 || ovf16 !== 1'b0 || count10 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_init: count16=%0d ovf16=%b count10=%0d, want 0 0 0", count16, ovf16, count10);
        end
        #1 rst = 1'b1;
        do_load(4'd9, 1'b1);
        n_tests++;
        if (count16 !== 4'd9) begin
            n_fail++;
            $display("FAIL reset_preload: count16=%0d, want 9", count16);
        end
        en = 1'b1; up = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (count16 !== 4'd0 || ovf16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: count16=%0d ovf16=%b, want 0 0", count16, ovf16);
        end
        #2 rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_tests++;
            if (count16 !== 4'(i)) begin
                n_fail++;
                $display("FAIL reset_resume_%0d: count16=%0d, want %0d", i, count16, i);
            end
        end
        // A step from the terminal value interrupted by reset must leave no ovf.
        do_load(4'd15, 1'b1);
        en = 1'b1; up = 1'b1;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        en = 1'b0;
        tick();
        n_tests++;
        if (ovf16 !== 1'b0 || count16 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_no_ovf: count16=%0d ovf16=%b, want 0 0", count16, ovf16);
        end
    endtask

    task automatic test_full_wrap();
        do_load(4'd0, 1'b1);
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (count16 !== 4'(i) || tc16 !== (i == 15) || ovf16 !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_seq_%0d: count16=%0d tc=%b ovf=%b, want %0d %b 0",
                         i, count16, tc16, ovf16, i, (i == 15));
            end
            tick();
        end
        n_tests++;
        if (count16 !== 4'd0 || ovf16 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_ovf: count16=%0d ovf=%b, want 0 1", count16, ovf16);
        end
        en = 1'b0;
        tick();
        n_tests++;
        if (count16 !== 4'd0 || ovf16 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_ovf_clear: count16=%0d ovf=%b, want 0 0", count16, ovf16);
        end
    endtask

    task automatic test_mod_down();
        logic [3:0] exp_c;
        do_load(4'd0, 1'b0);
        n_tests++;
        if (count10 !== 4'd0 || tc10 !== 1'b1) begin
            n_fail++;
            $display("FAIL mod_down_start: count10=%0d tc=%b, want 0 1", count10, tc10);
        end
        en = 1'b1; up = 1'b0;
        exp_c = 4'd0;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_c = (exp_c == 4'd0) ? 4'd9 : exp_c - 4'd1;
            n_tests++;
            if (count10 !== exp_c || ovf10 !== (exp_c == 4'd9) || count10 > 4'd9) begin
                n_fail++;
                $display("FAIL mod_down_%0d: count10=%0d ovf=%b, want %0d %b",
                         k, count10, ovf10, exp_c, (exp_c == 4'd9));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_clamp();
        load = 1'b1; en = 1'b1; up = 1'b1; load_val = 4'd13;
        tick();
        n_tests++;
        if (count10 !== 4'd9 || count16 !== 4'd13 || ovf10 !== 1'b0) begin
            n_fail++;
            $display("FAIL load_clamp: count10=%0d count16=%0d ovf10=%b, want 9 13 0", count10, count16, ovf10);
        end
        load_val = 4'd5;
        tick();
        n_tests++;
        if (count10 !== 4'd5 || count16 !== 4'd5) begin
            n_fail++;
            $display("FAIL load_priority: count10=%0d count16=%0d, want 5 5", count10, count16);
        end
        load = 1'b0; en = 1'b0;
        tick();
        tick();
        n_tests++;
        if (count10 !== 4'd5 || ovf10 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: count10=%0d ovf10=%b, want 5 0", count10, ovf10);
        end
    endtask

    task automatic test_dir_flip();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'd8, 4'd7, 4'd8, 4'd7};
        do_load(4'd7, 1'b1);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            up = (k % 2 == 0);
            tick();
            n_tests++;
            if (count16 !== exp_seq[k] || ovf16 !== 1'b0) begin
                n_fail++;
                $display("FAIL dir_flip_%0d: count16=%0d ovf=%b, want %0d 0", k, count16, ovf16, exp_seq[k]);
            end
        end
        en = 1'b0;
        // tc must follow up combinationally with no edge.
        up = 1'b0;
        do_load(4'd0, 1'b0);
        n_tests++;
        if (tc16 !== 1'b1) begin
            n_fail++;
            $display("FAIL tc_down: tc16=%b, want 1", tc16);
        end
        up = 1'b1;
        #1;
        n_tests++;
        if (tc16 !== 1'b0) begin
            n_fail++;
            $display("FAIL tc_up: tc16=%b, want 0", tc16);
        end
    endtask

    task automatic test_ends();
        logic [3:0] exp_c;
        logic       exp_o;
        do_load(4'd15, 1'b1);
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
`ifdef COUNTER_SAT_EN
            exp_c = 4'd15; exp_o = 1'b1;
`else
            exp_c = 4'(k); exp_o = (k == 0);
`endif
            n_tests++;
            if (count16 !== exp_c || ovf16 !== exp_o) begin
                n_fail++;
                $display("FAIL end_up_%0d: count16=%0d ovf=%b, want %0d %b", k, count16, ovf16, exp_c, exp_o);
            end
        end
        do_load(4'd0, 1'b0);
        en = 1'b1; up = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
`ifdef COUNTER_SAT_EN
            exp_c = 4'd0; exp_o = 1'b1;
`else
            exp_c = 4'(15 - k); exp_o = (k == 0);
`endif
            n_tests++;
            if (count16 !== exp_c || ovf16 !== exp_o) begin
                n_fail++;
                $display("FAIL end_down_%0d: count16=%0d ovf=%b, want %0d %b", k, count16, ovf16, exp_c, exp_o);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
        #2;
        test_reset();
        test_full_wrap();
        test_mod_down();
        test_load_clamp();
        test_dir_flip();
        test_ends();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_updown_counter.md
SYNC_UPDOWN_COUNTER -- requirements
Module: sync_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter bit width (>=1).
REQ-002 SHALL have parameter MODULUS, default 2**WIDTH, number of count states (0..MODULUS-1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  count enable; one step per enabled edge.
REQ-006 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port load  input  1  synchronous parallel load request.
REQ-008 SHALL have port load_val  input  WIDTH  value to load.
REQ-009 SHALL have port count  output  WIDTH  registered current count.
REQ-010 SHALL have port tc  output  1  combinational terminal count: (up && count==MODULUS-1) || (!up && count==0).
REQ-011 SHALL have port ovf  output  1  registered one-cycle pulse, set on the edge following an enabled step taken from the terminal value.

Function
REQ-012 SHALL fully synchronise the count: all bits change on the same clk edge; no bit is clocked by another bit.
REQ-013 SHALL give priority load > en; with load=1, count <= load_val on the edge, and en/up are ignored.
REQ-014 SHALL clamp load_val >= MODULUS to MODULUS-1 on load.
REQ-015 SHALL, with en=1 and load=0, step by exactly 1 in the direction of up; with en=0 and load=0, hold count.
REQ-016 SHALL, counting up from MODULUS-1, go to 0 (wrap); counting down from 0, go to MODULUS-1 (wrap), unless REQ-024 applies.
REQ-017 SHALL set ovf=1 for exactly one cycle after any enabled non-load step taken while tc=1; otherwise ovf=0.
REQ-018 SHALL sample up on each enabled edge; a direction change takes effect on the same edge it is presented, with no lost or doubled step.
REQ-019 SHALL have count latency of one edge from en/load to the updated count; tc follows count and up with no clock latency.
REQ-020 SHALL never let count exceed MODULUS-1 under any input sequence.

Reset
REQ-021 SHALL, while rst=0, immediately force count=0 and ovf=0, independent of clk.
REQ-022 SHALL resume counting on the first rising clk edge after rst deasserts; an edge coincident with deassertion may be ignored.
REQ-023 SHALL discard a load or step in progress when reset asserts mid-operation; no pending ovf survives reset.

Configuration
REQ-024 SHALL, with macro COUNTER_SAT_EN defined, saturate instead of wrapping: an enabled up step at MODULUS-1 or an enabled down step at 0 holds count, and ovf still pulses per REQ-017.
REQ-025 SHALL, without COUNTER_SAT_EN, wrap per REQ-016; the load, tc and reset behaviour is identical in both builds.

Structure
REQ-026 SHALL place shared constants in package counter_pkg: the default WIDTH and a function computing the terminal value (MODULUS-1).
REQ-027 SHALL build each count bit from sub-module t_cell: a T flip-flop with synchronous toggle enable, a synchronous load input and an asynchronous active-low clear. One t_cell is instantiated per bit in a generate loop.
REQ-028 SHALL derive the per-bit toggle enables from en, up and the lower bits. The wrap/saturate and load paths override through the t_cell load input.
REQ-029 SHALL fail elaboration when WIDTH < 1, MODULUS < 2 or MODULUS > 2**WIDTH.

Verification
REQ-030 SHALL check reset: WIDTH=4, drive rst=0 mid-count at count=9 -> count=0 and ovf=0 immediately without a clk edge; release -> count 1, 2, 3 on the next enabled edges.
REQ-031 SHALL check full-range wrap: WIDTH=4, default MODULUS, en=1, up=1 for 16 edges from 0 -> sequence 0..15, then 0; tc=1 at 15; ovf=1 for one cycle after the 15->0 edge.
REQ-032 SHALL check modulo down-count: WIDTH=4, MODULUS=10, load 0, up=0 -> 0, 9, 8, …; ovf pulses after the 0->9 edge; count never reaches 10..15.
REQ-033 SHALL check load priority and clamp: MODULUS=10, load=1 with en=1 and load_val=13 -> count=9 after one edge; load_val=5 with en=1 and up=1 -> count=5, not 6.
REQ-034 SHALL check a direction flip: count=7, up toggled 1/0 on alternating enabled edges -> 8, 7, 8, 7; ovf stays 0.
REQ-035 SHALL check saturation: build with COUNTER_SAT_EN, WIDTH=4, count=15, up=1, en=1 for 3 edges -> count stays 15 and ovf pulses once per edge; count=0, up=0 -> count stays 0.
